// File: rtl/reg_piso_pkg.sv
// reg_piso_pkg: shared FSM encodings and counter sizing for reg_piso_tx.
// Option: REG_PISO_PARITY_EN enables the even-parity PAR state.
package reg_piso_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    // Bit-counter width: clog2(width), never below one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/reg_piso_tx_if.sv
// reg_piso_tx_if: parallel load handshake and serial output bundle.
// Option: REG_PISO_PARITY_EN changes frame length only, not this bundle.
interface reg_piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             pl_i;
    logic [WIDTH-1:0] din_i;
    logic             din_valid_i;
    logic             ready_o;
    logic             do_o;
    logic             do_valid_o;
    logic             do_last_o;
    logic             busy_o;

    modport master (
        output pl_i, din_i, din_valid_i,
        input  ready_o, do_o, do_valid_o, do_last_o, busy_o
    );

    modport slave (
        input  pl_i, din_i, din_valid_i,
        output ready_o, do_o, do_valid_o, do_last_o, busy_o
    );
endinterface

// File: rtl/reg_piso_cnt.sv
// reg_piso_cnt: enabled bit counter, terminal count at WIDTH-1.
// Option: REG_PISO_PARITY_EN does not affect this block.
module reg_piso_cnt
    import reg_piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over enable so a load restarts the count at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/reg_piso_tx.sv
// reg_piso_tx: parallel-in serial-out transmitter, MSB first.
// Option: REG_PISO_PARITY_EN appends an even-parity bit carrying do_last.
module reg_piso_tx
    import reg_piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    reg_piso_tx_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    logic [1:0]       st_q, st_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             do_q, do_d;
    logic             dv_q, dv_d;
    logic             dl_q, dl_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CW-1:0]    cnt;
    logic             tc;
`ifdef REG_PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    reg_piso_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    // Next-state: pl low holds everything, otherwise load/shift/finish.
    always_comb begin
        st_d    = st_q;
        sh_d    = sh_q;
        do_d    = do_q;
        dv_d    = dv_q;
        dl_d    = dl_q;
        busy_d  = busy_q;
        rdy_d   = rdy_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef REG_PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (bus.pl_i) begin
            unique case (st_q)
                ST_IDLE: begin
                    if (bus.din_valid_i) begin
                        sh_d    = bus.din_i;
                        do_d    = bus.din_i[WIDTH-1];
                        dv_d    = 1'b1;
                        dl_d    = 1'b0;
                        busy_d  = 1'b1;
                        rdy_d   = 1'b0;
                        cnt_clr = 1'b1;
                        st_d    = ST_SHIFT;
`ifdef REG_PISO_PARITY_EN
                        par_d   = ^bus.din_i;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (!tc) begin
                        cnt_en = 1'b1;
                        sh_d   = sh_q << 1;
                        do_d   = sh_q[WIDTH-2];
`ifdef REG_PISO_PARITY_EN
                        dl_d   = 1'b0;
`else
                        dl_d   = (cnt == CW'(WIDTH - 2));
`endif
                    end else begin
`ifdef REG_PISO_PARITY_EN
                        do_d = par_q;
                        dl_d = 1'b1;
                        st_d = ST_PAR;
`else
                        do_d    = 1'b0;
                        dv_d    = 1'b0;
                        dl_d    = 1'b0;
                        busy_d  = 1'b0;
                        rdy_d   = 1'b1;
                        cnt_clr = 1'b1;
                        st_d    = ST_IDLE;
`endif
                    end
                end
`ifdef REG_PISO_PARITY_EN
                ST_PAR: begin
                    do_d    = 1'b0;
                    dv_d    = 1'b0;
                    dl_d    = 1'b0;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    cnt_clr = 1'b1;
                    st_d    = ST_IDLE;
                end
`endif
                default: begin
                    do_d    = 1'b0;
                    dv_d    = 1'b0;
                    dl_d    = 1'b0;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    cnt_clr = 1'b1;
                    st_d    = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= ST_IDLE;
            sh_q   <= '0;
            do_q   <= 1'b0;
            dv_q   <= 1'b0;
            dl_q   <= 1'b0;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            st_q   <= st_d;
            sh_q   <= sh_d;
            do_q   <= do_d;
            dv_q   <= dv_d;
            dl_q   <= dl_d;
            busy_q <= busy_d;
            rdy_q  <= rdy_d;
        end
    end

`ifdef REG_PISO_PARITY_EN
    // Parity of the loaded word, captured with the word itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign bus.do_o       = do_q;
    assign bus.do_valid_o = dv_q;
    assign bus.do_last_o  = dl_q;
    assign bus.busy_o     = busy_q;
    assign bus.ready_o    = rdy_q;

endmodule
